hazard_scoreboard: RTL

// - Parametrised successor to the ID-stage hazard detector: per-register pending-write scoreboard with countdown timers.
// - Sits in ID; drives `freeze` to hold IF/ID and insert a bubble into ID/EXE.
// - Supports NUM_SRC sources per instruction and separate load-use and no-forwarding stall depths.
// - Tracks stall cycles for performance counting.

---
 rtl/hazard_pkg.sv | 9 +
 rtl/haz_timer.sv | 22 ++
 rtl/hazard_scoreboard.sv | 57 +++++
 3 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared defaults and helpers for the hazard scoreboard
package hazard_pkg;
  localparam int REG_W_DEF = 4;
  localparam int LOAD_STALL_DEF = 1;
  localparam int NOFWD_STALL_DEF = 2;
  function automatic int max(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/haz_timer.sv
// haz_timer: per-register pending-write down-counter with load-max
// clk, rst_n : clock, async active-low reset
// load       : producer of this register issues this cycle
// ld_val     : new wait depth; kept only if longer than the decremented count
// cnt        : remaining bubbles before the register is safe to read
module haz_timer
  import hazard_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] ld_val,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] dec;
  assign dec = (cnt != '0) ? cnt - CNT_W'(1) : '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? CNT_W'(max(int'(dec), int'(ld_val))) : dec;
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage pending-write scoreboard driving freeze
// forward_en             : forwarding unit active (selects load/no-forward depth)
// id_valid, id_src[_vld] : ID instruction and its read operands
// id_dest, id_wb_en      : destination written by the ID instruction
// id_mem_r, flush        : instruction is a load / ID instruction squashed
// freeze                 : hold IF/ID, bubble ID/EXE
// pend_mask, stall_count : per-register pending bits, saturating stall cycles
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int NUM_SRC     = 2,
  parameter int LOAD_STALL  = LOAD_STALL_DEF,
  parameter int NOFWD_STALL = NOFWD_STALL_DEF,
  parameter int CNT_W       = 2,
  parameter int STAT_W      = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     forward_en,
  input  logic                     id_valid,
  input  logic [NUM_SRC*REG_W-1:0] id_src,
  input  logic [NUM_SRC-1:0]       id_src_vld,
  input  logic [REG_W-1:0]         id_dest,
  input  logic                     id_wb_en,
  input  logic                     id_mem_r,
  input  logic                     flush,
  output logic                     freeze,
  output logic [2**REG_W-1:0]      pend_mask,
  output logic [STAT_W-1:0]        stall_count
);
  localparam int NUM_REGS = 2**REG_W;
  logic [CNT_W-1:0] timer [NUM_REGS];
  logic [CNT_W-1:0] ld_val;
  logic hit, issue;
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < NUM_SRC; k++)
      hit = hit | (id_src_vld[k] & pend_mask[id_src[k*REG_W +: REG_W]]);
  end
  assign freeze = id_valid & ~flush & hit;
  assign issue  = id_valid & ~flush & ~freeze & id_wb_en;
  assign ld_val = forward_en ? (id_mem_r ? CNT_W'(LOAD_STALL) : '0) : CNT_W'(NOFWD_STALL);
  for (genvar g = 0; g < NUM_REGS; g++) begin : g_tmr
    haz_timer #(.CNT_W(CNT_W)) u_tmr (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (issue && id_dest == REG_W'(g)),
      .ld_val (ld_val),
      .cnt    (timer[g])
    );
    assign pend_mask[g] = timer[g] != '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) stall_count <= '0;
    else if (freeze && !(&stall_count)) stall_count <= stall_count + STAT_W'(1);
endmodule
